// File: rtl/vga_frame_receiver.sv
// rtl/vga_frame_receiver.sv - VGA stream monitor: coordinate recovery, timing lock and lit-pixel bounding box
module vga_frame_receiver #(
    parameter int VIDEO_WIDTH = 3,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_TOTAL     = 800,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_TOTAL     = 525
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   pix_ce,
    input  logic                   hsync,
    input  logic                   vsync,
    input  logic [VIDEO_WIDTH-1:0] red,
    input  logic [VIDEO_WIDTH-1:0] green,
    input  logic [VIDEO_WIDTH-1:0] blue,
    output logic [9:0]             col,
    output logic [9:0]             row,
    output logic                   active,
    output logic                   locked,
    output logic                   err,
    output logic                   frame_done,
    output logic                   obj_valid,
    output logic [9:0]             obj_x_min,
    output logic [9:0]             obj_x_max,
    output logic [9:0]             obj_y_min,
    output logic [9:0]             obj_y_max
);

    localparam logic [9:0] COL_HS   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] ROW_VS   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] COL_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] ROW_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_TOT    = 10'(H_TOTAL);
    localparam logic [9:0] V_TOT    = 10'(V_TOTAL);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] CNT_MAX  = 10'h3FF;

    logic       hs_q, hs_d, vs_q, vs_d;
    logic [9:0] col_q, col_d, row_q, row_d;
    logic       active_q, active_d;
    logic [9:0] line_cnt_q, line_cnt_d, tally_q, tally_d;
    logic       hs_seen_q, hs_seen_d, vs_seen_q, vs_seen_d;
    logic [1:0] good_lines_q, good_lines_d;
    logic       frame_ok_q, frame_ok_d;
    logic       locked_q, locked_d, err_q, err_d;
    logic       frame_done_q, frame_done_d, obj_valid_q, obj_valid_d;
    logic [9:0] box_x0_q, box_x0_d, box_x1_q, box_x1_d;
    logic [9:0] box_y0_q, box_y0_d, box_y1_q, box_y1_d;
    logic [9:0] acc_x0_q, acc_x0_d, acc_x1_q, acc_x1_d;
    logic [9:0] acc_y0_q, acc_y0_d, acc_y1_q, acc_y1_d;
    logic       seen_q, seen_d;

    logic       hs_fall, vs_fall, col_wrap, lit, line_bad, frame_bad;
    logic [9:0] base_x0, base_x1, base_y0, base_y1;
    logic       base_seen;

    always_comb begin
        hs_d = hs_q;  vs_d = vs_q;
        col_d = col_q;  row_d = row_q;  active_d = active_q;
        line_cnt_d = line_cnt_q;  tally_d = tally_q;
        hs_seen_d = hs_seen_q;  vs_seen_d = vs_seen_q;
        good_lines_d = good_lines_q;  frame_ok_d = frame_ok_q;
        locked_d = locked_q;  err_d = err_q;
        frame_done_d = 1'b0;  obj_valid_d = obj_valid_q;
        box_x0_d = box_x0_q;  box_x1_d = box_x1_q;
        box_y0_d = box_y0_q;  box_y1_d = box_y1_q;
        acc_x0_d = acc_x0_q;  acc_x1_d = acc_x1_q;
        acc_y0_d = acc_y0_q;  acc_y1_d = acc_y1_q;
        seen_d = seen_q;
        hs_fall = 1'b0;  vs_fall = 1'b0;  col_wrap = 1'b0;  lit = 1'b0;
        line_bad = 1'b0;  frame_bad = 1'b0;
        base_x0 = acc_x0_q;  base_x1 = acc_x1_q;
        base_y0 = acc_y0_q;  base_y1 = acc_y1_q;
        base_seen = seen_q;

        if (pix_ce) begin
            hs_fall = hs_q & ~hsync;
            vs_fall = vs_q & ~vsync;
            hs_d    = hsync;
            vs_d    = vsync;

            if (hs_fall) begin
                col_d = COL_HS;
            end else if (col_q == COL_LAST) begin
                col_d    = 10'd0;
                col_wrap = 1'b1;
            end else begin
                col_d = col_q + 10'd1;
            end

            if (vs_fall) begin
                row_d = ROW_VS;
            end else if (col_wrap) begin
                row_d = (row_q == ROW_LAST) ? 10'd0 : row_q + 10'd1;
            end

            active_d = (col_d < H_ACT) && (row_d < V_ACT);
            lit      = active_d && ((red | green | blue) != '0);

            // Counts only become meaningful once a first edge has opened a full period.
            if (hs_fall) begin
                line_bad   = hs_seen_q && ((line_cnt_q == CNT_MAX) || (line_cnt_q != H_TOT));
                hs_seen_d  = 1'b1;
                line_cnt_d = 10'd1;
                if (hs_seen_q)
                    good_lines_d = line_bad ? 2'd0 :
                                   (good_lines_q == 2'd2) ? 2'd2 : good_lines_q + 2'd1;
            end else if (line_cnt_q != CNT_MAX) begin
                line_cnt_d = line_cnt_q + 10'd1;
            end

            if (vs_fall) begin
                frame_bad = vs_seen_q && ((tally_q == CNT_MAX) || (tally_q != V_TOT));
                if (vs_seen_q)
                    frame_ok_d = ~frame_bad;
                vs_seen_d = 1'b1;
                tally_d   = {9'd0, hs_fall};
            end else if (hs_fall && (tally_q != CNT_MAX)) begin
                tally_d = tally_q + 10'd1;
            end

            if (line_bad)
                frame_ok_d = 1'b0;

            if (line_bad || frame_bad) begin
                locked_d = 1'b0;
                err_d    = 1'b1;
            end else if ((good_lines_d == 2'd2) && frame_ok_d) begin
                locked_d = 1'b1;
            end

            // The pixel sampled with the vsync edge starts the new frame's accumulation.
            if (vs_fall) begin
                frame_done_d = 1'b1;
                obj_valid_d  = seen_q && locked_d;
                if (seen_q) begin
                    box_x0_d = acc_x0_q;  box_x1_d = acc_x1_q;
                    box_y0_d = acc_y0_q;  box_y1_d = acc_y1_q;
                end
                base_x0 = CNT_MAX;  base_x1 = 10'd0;
                base_y0 = CNT_MAX;  base_y1 = 10'd0;
                base_seen = 1'b0;
            end

            acc_x0_d = base_x0;  acc_x1_d = base_x1;
            acc_y0_d = base_y0;  acc_y1_d = base_y1;
            seen_d   = base_seen;
            if (lit) begin
                if (col_d < base_x0) acc_x0_d = col_d;
                if (col_d > base_x1) acc_x1_d = col_d;
                if (row_d < base_y0) acc_y0_d = row_d;
                if (row_d > base_y1) acc_y1_d = row_d;
                seen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            hs_q <= 1'b1;  vs_q <= 1'b1;
            col_q <= '0;  row_q <= '0;  active_q <= 1'b0;
            line_cnt_q <= '0;  tally_q <= '0;
            hs_seen_q <= 1'b0;  vs_seen_q <= 1'b0;
            good_lines_q <= '0;  frame_ok_q <= 1'b0;
            locked_q <= 1'b0;  err_q <= 1'b0;
            frame_done_q <= 1'b0;  obj_valid_q <= 1'b0;
            box_x0_q <= '0;  box_x1_q <= '0;  box_y0_q <= '0;  box_y1_q <= '0;
            acc_x0_q <= CNT_MAX;  acc_x1_q <= '0;
            acc_y0_q <= CNT_MAX;  acc_y1_q <= '0;
            seen_q <= 1'b0;
        end else begin
            hs_q <= hs_d;  vs_q <= vs_d;
            col_q <= col_d;  row_q <= row_d;  active_q <= active_d;
            line_cnt_q <= line_cnt_d;  tally_q <= tally_d;
            hs_seen_q <= hs_seen_d;  vs_seen_q <= vs_seen_d;
            good_lines_q <= good_lines_d;  frame_ok_q <= frame_ok_d;
            locked_q <= locked_d;  err_q <= err_d;
            frame_done_q <= frame_done_d;  obj_valid_q <= obj_valid_d;
            box_x0_q <= box_x0_d;  box_x1_q <= box_x1_d;
            box_y0_q <= box_y0_d;  box_y1_q <= box_y1_d;
            acc_x0_q <= acc_x0_d;  acc_x1_q <= acc_x1_d;
            acc_y0_q <= acc_y0_d;  acc_y1_q <= acc_y1_d;
            seen_q <= seen_d;
        end
    end

    assign col        = col_q;
    assign row        = row_q;
    assign active     = active_q;
    assign locked     = locked_q;
    assign err        = err_q;
    assign frame_done = frame_done_q;
    assign obj_valid  = obj_valid_q;
    assign obj_x_min  = box_x0_q;
    assign obj_x_max  = box_x1_q;
    assign obj_y_min  = box_y0_q;
    assign obj_y_max  = box_y1_q;

endmodule

// File: tb/tb_vga_frame_receiver.sv
// tb/tb_vga_frame_receiver.sv - scoreboard bench for vga_frame_receiver on a reduced raster
module tb_vga_frame_receiver;

    // Reduced raster keeps each frame at 2000 samples.
    localparam int VW  = 3;
    localparam int HA  = 32, HFP = 4, HSW = 6, HT = 50;
    localparam int VA  = 24, VFP = 2, VSW = 2, VT = 40;

    typedef struct packed {
        logic       v;
        logic [9:0] x0, x1, y0, y1;
    } exp_t;

    logic          clk = 1'b0;
    logic          clr, pix_ce, hsync, vsync;
    logic [VW-1:0] red, green, blue;
    logic [9:0]    col, row, obj_x_min, obj_x_max, obj_y_min, obj_y_max;
    logic          active, locked, err, frame_done, obj_valid;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   gx = 0, gy = 0, scene = 0;
    bit   half = 1'b0;
    exp_t sb[$];
    exp_t exp_next;

    localparam exp_t SQ   = '{v: 1'b1, x0: 10'd12, x1: 10'd15, y0: 10'd6, y1: 10'd9};
    localparam exp_t OBJS = '{v: 1'b1, x0: 10'd0,  x1: 10'd27, y0: 10'd3, y1: 10'd15};

    vga_frame_receiver #(
        .VIDEO_WIDTH(VW), .H_ACTIVE(HA), .H_FP(HFP), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_FP(VFP), .V_TOTAL(VT)
    ) dut (
        .clk(clk), .clr(clr), .pix_ce(pix_ce), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .col(col), .row(row), .active(active), .locked(locked), .err(err),
        .frame_done(frame_done), .obj_valid(obj_valid),
        .obj_x_min(obj_x_min), .obj_x_max(obj_x_max),
        .obj_y_min(obj_y_min), .obj_y_max(obj_y_max)
    );

    always #5 clk = ~clk;

    function automatic logic lit_at(int s, int x, int y);
        if (s == 1) return (x >= 12 && x <= 15 && y >= 6 && y <= 9);
        if (s == 2) return (x <= 1 && y >= 8 && y <= 15) || (x >= 24 && x <= 27 && y >= 3 && y <= 5);
        return 1'b0;
    endfunction

    function automatic exp_t with_valid(exp_t e, logic v);
        exp_t r = e;
        r.v = v;
        return r;
    endfunction

    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            exp_t e;
            exp_t got;
            n_tests++;
            got = '{v: obj_valid, x0: obj_x_min, x1: obj_x_max, y0: obj_y_min, y1: obj_y_max};
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL frame_done_unexpected: got pulse at %0t, required none", $time);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL frame_box: got v=%0b %0d/%0d/%0d/%0d, required v=%0b %0d/%0d/%0d/%0d",
                             got.v, got.x0, got.x1, got.y0, got.y1, e.v, e.x0, e.x1, e.y0, e.y1);
                end
            end
        end
    end

    task automatic step();
        logic l;
        l      = lit_at(scene, gx, gy);
        hsync  = !(gx >= HA + HFP && gx < HA + HFP + HSW);
        vsync  = !(gy >= VA + VFP && gy < VA + VFP + VSW);
        red    = l ? 3'b111 : 3'b000;
        green  = l ? 3'b111 : 3'b000;
        blue   = l ? 3'b111 : 3'b000;
        pix_ce = 1'b1;
        if (gx == 0 && gy == VA + VFP) sb.push_back(exp_next);
        @(posedge clk); #1;
        if (half) begin
            pix_ce = 1'b0;
            hsync  = 1'($urandom_range(0, 1));
            vsync  = 1'($urandom_range(0, 1));
            red    = 3'($urandom_range(1, 7));
            green  = 3'($urandom_range(0, 7));
            blue   = 3'($urandom_range(0, 7));
            @(posedge clk); #1;
        end
        gx++;
        if (gx == HT) begin
            gx = 0;
            gy++;
            if (gy == VT) gy = 0;
        end
    endtask

    task automatic run_frame();
        do step(); while (!(gx == 0 && gy == 0));
    endtask

    task automatic apply_clr();
        clr = 1'b1; pix_ce = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if ({col, row, active, locked, err, frame_done, obj_valid,
             obj_x_min, obj_x_max, obj_y_min, obj_y_max} !== '0) begin
            n_fail++;
            $display("FAIL clr_outputs: got col=%0d row=%0d act=%0b lk=%0b err=%0b fd=%0b ov=%0b box=%0d/%0d/%0d/%0d, required all 0",
                     col, row, active, locked, err, frame_done, obj_valid,
                     obj_x_min, obj_x_max, obj_y_min, obj_y_max);
        end
        clr = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1; pix_ce = 1'b0; hsync = 1'b1; vsync = 1'b1;
        red = '0; green = '0; blue = '0;
        repeat (2) @(posedge clk);
        #1;
        apply_clr();
        gx = 0; gy = 0;
    endtask

    task automatic test_square();
        scene = 1;
        exp_next = with_valid(SQ, 1'b0);
        do begin
            int x;
            int y;
            x = gx; y = gy;
            step();
            if (x == 5 && y == 3) begin
                n_tests++;
                if ({col, row, active} !== {10'd5, 10'd3, 1'b1}) begin
                    n_fail++;
                    $display("FAIL coord_active: got col=%0d row=%0d act=%0b, required 5 3 1", col, row, active);
                end
            end
            if (x == 40 && y == 3) begin
                n_tests++;
                if ({col, row, active} !== {10'd40, 10'd3, 1'b0}) begin
                    n_fail++;
                    $display("FAIL coord_blank: got col=%0d row=%0d act=%0b, required 40 3 0", col, row, active);
                end
            end
            if (x == 0 && y == VA + VFP) begin
                n_tests++;
                if (locked !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lock_partial_frame: got %0b, required 0", locked);
                end
            end
        end while (!(gx == 0 && gy == 0));
        exp_next = SQ;
        do begin
            int x;
            int y;
            x = gx; y = gy;
            step();
            if (x == 0 && y == VA + VFP) begin
                n_tests++;
                if ({locked, err} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL lock_second_vsync: got locked=%0b err=%0b, required 1 0", locked, err);
                end
            end
        end while (!(gx == 0 && gy == 0));
    endtask

    task automatic test_black_frame();
        scene = 0;
        exp_next = with_valid(SQ, 1'b0);
        run_frame();
    endtask

    task automatic test_two_objects();
        scene = 2;
        exp_next = OBJS;
        run_frame();
    endtask

    task automatic test_bad_line();
        scene = 1;
        exp_next = SQ;
        do begin
            int x;
            int y;
            if (gx == 20 && gy == 12) begin
                n_tests++;
                if ({locked, err} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL before_bad_line: got locked=%0b err=%0b, required 1 0", locked, err);
                end
                gx++;
            end
            x = gx; y = gy;
            step();
            if (x == HA + HFP && y == 12) begin
                n_tests++;
                if ({locked, err} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL at_bad_line: got locked=%0b err=%0b, required 0 1", locked, err);
                end
            end
        end while (!(gx == 0 && gy == 0));
        n_tests++;
        if ({locked, err} !== 2'b11) begin
            n_fail++;
            $display("FAIL relock_err_sticky: got locked=%0b err=%0b, required 1 1", locked, err);
        end
    endtask

    task automatic test_half_rate();
        apply_clr();
        gx = 0; gy = 0; half = 1'b1; scene = 1;
        exp_next = with_valid(SQ, 1'b0);
        do begin
            int x;
            int y;
            x = gx; y = gy;
            step();
            if (x == 5 && y == 3) begin
                n_tests++;
                if ({col, row, active} !== {10'd5, 10'd3, 1'b1}) begin
                    n_fail++;
                    $display("FAIL half_coord: got col=%0d row=%0d act=%0b, required 5 3 1", col, row, active);
                end
            end
        end while (!(gx == 0 && gy == 0));
        exp_next = SQ;
        run_frame();
        half = 1'b0;
        n_tests++;
        if ({locked, err} !== 2'b10) begin
            n_fail++;
            $display("FAIL half_lock: got locked=%0b err=%0b, required 1 0", locked, err);
        end
    endtask

    task automatic test_clr_mid_frame();
        scene = 1;
        exp_next = '0;
        while (!(gx == 0 && gy == VA / 2)) step();
        apply_clr();
        run_frame();
        exp_next = SQ;
        run_frame();
        n_tests++;
        if ({locked, err} !== 2'b10) begin
            n_fail++;
            $display("FAIL clr_relock: got locked=%0b err=%0b, required 1 0", locked, err);
        end
    endtask

    initial begin
        test_reset();
        test_square();
        test_black_frame();
        test_two_objects();
        test_bad_line();
        test_half_rate();
        test_clr_mid_frame();
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL frame_done_missing: got %0d pending, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
